// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_bus_arbiter_if : one SRAM-style request/response channel
// Revision 1.0
// ---------------------------------------------------------------------------
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_bus_arbiter : fixed-priority fetch/load-store arbiter onto one SRAM bus
// Revision 1.0
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  sram_bus_arbiter_if.slave  inst_if,
  sram_bus_arbiter_if.slave  data_if,
  sram_bus_arbiter_if.master bus_if
);

  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL_COUNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } lock_state_e;

  lock_state_e                state_q, state_d;
  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;

  logic sel_valid;
  logic sel_data;
  logic full;
  logic empty;
  logic grant;
  logic push;
  logic pop;
  logic head_owner;

  // A stalled owner keeps the bus only while it still requests.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 1'b0;
    if (state_q == ST_LOCK_INST && inst_if.req) begin
      sel_valid = 1'b1;
      sel_data  = 1'b0;
    end else if (state_q == ST_LOCK_DATA && data_if.req) begin
      sel_valid = 1'b1;
      sel_data  = 1'b1;
    end else if (data_if.req) begin
      sel_valid = 1'b1;
      sel_data  = 1'b1;
    end else if (inst_if.req) begin
      sel_valid = 1'b1;
      sel_data  = 1'b0;
    end
  end

  assign full       = (count_q == C_FULL_COUNT);
  assign empty      = (count_q == '0);
  assign grant      = sel_valid & ~full & ~reset;
  assign push       = grant & bus_if.addr_ok;
  assign pop        = bus_if.data_ok & ~empty & ~reset;
  assign head_owner = owner_q[rd_ptr_q];

  assign bus_if.req   = grant;
  assign bus_if.wr    = sel_data ? data_if.wr    : inst_if.wr;
  assign bus_if.size  = sel_data ? data_if.size  : inst_if.size;
  assign bus_if.wstrb = sel_data ? data_if.wstrb : inst_if.wstrb;
  assign bus_if.addr  = sel_data ? data_if.addr  : inst_if.addr;
  assign bus_if.wdata = sel_data ? data_if.wdata : inst_if.wdata;

  assign inst_if.addr_ok = push & ~sel_data;
  assign data_if.addr_ok = push &  sel_data;

  assign inst_if.data_ok = pop & ~head_owner;
  assign data_if.data_ok = pop &  head_owner;
  assign inst_if.rdata   = bus_if.rdata;
  assign data_if.rdata   = bus_if.rdata;

  always_comb begin
    state_d  = ST_FREE;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (grant && !bus_if.addr_ok) begin
      state_d = sel_data ? ST_LOCK_DATA : ST_LOCK_INST;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FREE;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        owner_q[wr_ptr_q] <= sel_data;
      end
    end
  end

  a_single_addr_ok : assert property (@(posedge clk) disable iff (reset)
    !(inst_if.addr_ok && data_if.addr_ok));
  a_single_data_ok : assert property (@(posedge clk) disable iff (reset)
    !(inst_if.data_ok && data_if.data_ok));
  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    !(push && full));

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter : directed + randomized check against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_bus_arbiter_if inst_if ();
  sram_bus_arbiter_if data_if ();
  sram_bus_arbiter_if bus_if ();

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk     (clk),
    .reset   (reset),
    .inst_if (inst_if),
    .data_if (data_if),
    .bus_if  (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: queue of owner ids in acceptance order, plus current lock owner.
  int mq[$];
  int lock_own = -1;
  bit inst_acc = 1'b0;
  bit data_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cand_owner();
    if (lock_own == 0 && inst_if.req) return 0;
    if (lock_own == 1 && data_if.req) return 1;
    if (data_if.req) return 1;
    if (inst_if.req) return 0;
    return -1;
  endfunction

  function automatic bit m_breq();
    return !reset && cand_owner() != -1 && mq.size() < MAXO;
  endfunction

  function automatic bit m_pop();
    return !reset && bus_if.data_ok && mq.size() > 0;
  endfunction

  task automatic model_clear();
    mq.delete();
    lock_own = -1;
    inst_acc = 1'b0;
    data_acc = 1'b0;
  endtask

  task automatic model_step();
    int  c;
    bit  breq, acc;
    if (reset) begin
      model_clear();
    end else begin
      c    = cand_owner();
      breq = m_breq();
      acc  = breq && bus_if.addr_ok;
      inst_acc = acc && c == 0;
      data_acc = acc && c == 1;
      if (m_pop()) void'(mq.pop_front());
      if (acc) mq.push_back(c);
      lock_own = (breq && !bus_if.addr_ok) ? c : -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    int c;
    bit breq, acc, pop;
    c    = cand_owner();
    breq = m_breq();
    acc  = breq && bus_if.addr_ok;
    pop  = m_pop();
    chk("bus_req", {31'd0, bus_if.req}, {31'd0, breq});
    chk("inst_addr_ok", {31'd0, inst_if.addr_ok}, {31'd0, acc && c == 0});
    chk("data_addr_ok", {31'd0, data_if.addr_ok}, {31'd0, acc && c == 1});
    chk("inst_data_ok", {31'd0, inst_if.data_ok}, {31'd0, pop && mq[0] == 0});
    chk("data_data_ok", {31'd0, data_if.data_ok}, {31'd0, pop && mq[0] == 1});
    chk("inst_rdata", inst_if.rdata, bus_if.rdata);
    chk("data_rdata", data_if.rdata, bus_if.rdata);
    if (breq) begin
      chk("bus_addr", bus_if.addr, c == 1 ? data_if.addr : inst_if.addr);
      chk("bus_wdata", bus_if.wdata, c == 1 ? data_if.wdata : inst_if.wdata);
      chk("bus_ctl", {25'd0, bus_if.wr, bus_if.size, bus_if.wstrb},
          c == 1 ? {25'd0, data_if.wr, data_if.size, data_if.wstrb}
                 : {25'd0, inst_if.wr, inst_if.size, inst_if.wstrb});
    end
  end

  task automatic drive(input int s, input bit r, input logic [31:0] a);
    if (s == 0) begin
      inst_if.req = r;   inst_if.addr = a;  inst_if.wdata = {a[15:0], a[31:16]};
      inst_if.wr = a[0]; inst_if.size = a[2:1]; inst_if.wstrb = a[7:4];
    end else begin
      data_if.req = r;   data_if.addr = a;  data_if.wdata = {a[15:0], a[31:16]};
      data_if.wr = a[0]; data_if.size = a[2:1]; data_if.wstrb = a[7:4];
    end
  endtask

  task automatic drain(input int n);
    bus_if.data_ok = 1'b1;
    repeat (n) tick();
    bus_if.data_ok = 1'b0;
  endtask

  // One request per cycle, strictly alternating inst/data starting with inst.
  task automatic fill4();
    bus_if.addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(k % 2, 1'b1, 32'h1000 + 32'(k) * 4);
      drive(1 - (k % 2), 1'b0, 32'h0);
      tick();
    end
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
  endtask

  bit acc_s, req_s;

  initial begin
    reset = 1'b1;
    drive(0, 1'b1, 32'h55);
    drive(1, 1'b1, 32'h66);
    bus_if.addr_ok = 1'b1;
    bus_if.data_ok = 1'b1;
    bus_if.rdata   = 32'hdeadbeef;
    #1;
    chk("rst_bus_req", {31'd0, bus_if.req}, 32'd0);
    chk("rst_addr_ok", {30'd0, inst_if.addr_ok, data_if.addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    bus_if.data_ok = 1'b0;
    tick();

    // Both request: data first, inst next cycle.
    drive(0, 1'b1, 32'h100);
    drive(1, 1'b1, 32'h200);
    #1;
    chk("pri_addr", bus_if.addr, 32'h200);
    chk("pri_aok", {30'd0, inst_if.addr_ok, data_if.addr_ok}, 32'd1);
    tick();
    drive(1, 1'b0, 32'h0);
    #1;
    chk("pri2_aok", {30'd0, inst_if.addr_ok, data_if.addr_ok}, 32'd2);
    tick();
    drive(0, 1'b0, 32'h0);
    bus_if.data_ok = 1'b1;
    #1;
    chk("rsp_first_data", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd1);
    tick();
    #1;
    chk("rsp_second_inst", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd2);
    tick();
    bus_if.data_ok = 1'b0;

    // Lock: inst stalls 3 cycles, data arrives in cycle 2 and must wait.
    bus_if.addr_ok = 1'b0;
    drive(0, 1'b1, 32'h300);
    for (int k = 1; k <= 3; k++) begin
      if (k == 2) drive(1, 1'b1, 32'h400);
      #1;
      chk("lock_addr", bus_if.addr, 32'h300);
      tick();
    end
    bus_if.addr_ok = 1'b1;
    #1;
    chk("lock_accept", {30'd0, inst_if.addr_ok, data_if.addr_ok}, 32'd2);
    tick();
    drive(0, 1'b0, 32'h0);
    #1;
    chk("after_lock", {30'd0, inst_if.addr_ok, data_if.addr_ok}, 32'd1);
    chk("after_lock_addr", bus_if.addr, 32'h400);
    tick();
    drive(1, 1'b0, 32'h0);
    drain(2);

    // Full tracker blocks the bus; responses return in acceptance order.
    fill4();
    drive(0, 1'b1, 32'h500);
    drive(1, 1'b1, 32'h600);
    #1;
    chk("full_breq", {31'd0, bus_if.req}, 32'd0);
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    bus_if.data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("order", {30'd0, inst_if.data_ok, data_if.data_ok}, (k % 2 == 0) ? 32'd2 : 32'd1);
      tick();
    end
    // Empty: stray response is ignored.
    #1;
    chk("empty_rsp", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    tick();
    bus_if.data_ok = 1'b0;

    // Full with same-cycle pop and request: pop only, accept next cycle.
    fill4();
    drive(1, 1'b1, 32'h700);
    bus_if.data_ok = 1'b1;
    #1;
    chk("popfull_breq", {31'd0, bus_if.req}, 32'd0);
    chk("popfull_rsp", {31'd0, inst_if.data_ok}, 32'd1);
    tick();
    bus_if.data_ok = 1'b0;
    #1;
    chk("popfull_next", {31'd0, data_if.addr_ok}, 32'd1);
    tick();
    drive(1, 1'b0, 32'h0);
    drain(4);

    // Reset with two outstanding and a held lock.
    bus_if.addr_ok = 1'b1;
    drive(0, 1'b1, 32'h800);
    tick(); tick();
    bus_if.addr_ok = 1'b0;
    tick();
    reset = 1'b1;
    model_clear();
    bus_if.data_ok = 1'b1;
    #1;
    chk("midrst_breq", {31'd0, bus_if.req}, 32'd0);
    chk("midrst_dok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1, 1'b1, 32'h900);
    bus_if.addr_ok = 1'b1;
    #1;
    chk("postrst_dok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    chk("postrst_grant", bus_if.addr, 32'h900);
    tick();
    drive(0, 1'b0, 32'h0);
    drive(1, 1'b0, 32'h0);
    bus_if.data_ok = 1'b0;
    tick();

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        acc_s = (s == 0) ? inst_acc : data_acc;
        req_s = (s == 0) ? inst_if.req : data_if.req;
        if (acc_s || !req_s) begin
          drive(s, $urandom_range(0, 99) < 60, $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          drive(s, 1'b0, $urandom);
        end
      end
      bus_if.addr_ok = 1'($urandom_range(0, 1));
      bus_if.data_ok = $urandom_range(0, 99) < 45;
      bus_if.rdata   = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        model_clear();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
